alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_pkg.sv | 69 ++++++
 rtl/alu_decode.sv | 101 ++++++++++
 rtl/alu_issue.sv | 93 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the issue stage and the execute-stage ALU:
// op codes, instruction kinds, RV32I opcodes and the buffered entry layout.
`timescale 1ns/1ps
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JUMP   = 3'd4
    } kind_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam int ISSUE_DEPTH = 2;

    typedef struct packed {
        alu_ctrl_e   alu_ctrl;
        kind_e       kind;
        logic        illegal;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        reg_write;
        logic [2:0]  funct3;
    } entry_t;

    // Register/immediate arithmetic mapping; alt is instr[30], SUB only exists for register form.
    function automatic alu_ctrl_e arith_ctrl(input logic [2:0] f3, input logic alt,
                                             input logic allow_sub);
        alu_ctrl_e c;
        case (f3)
            3'b000:  c = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'b001:  c = ALU_SLL;
            3'b010:  c = ALU_SLT;
            3'b011:  c = ALU_SLTU;
            3'b100:  c = ALU_XOR;
            3'b101:  c = alt ? ALU_SRA : ALU_SRL;
            3'b110:  c = ALU_OR;
            default: c = ALU_AND;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode of one instruction into an issue-buffer entry.
`timescale 1ns/1ps
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output entry_t      o_entry
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    entry_t      w_entry;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u  = {i_instr[31:12], 12'h000};
    assign w_imm_j  = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        w_entry          = '0;
        w_entry.alu_ctrl = ALU_ADD;
        w_entry.kind     = KIND_ALU;
        w_entry.pc       = i_pc;
        w_entry.rd       = i_instr[11:7];
        w_entry.funct3   = w_f3;
        case (w_opcode)
            OPC_OP: begin
                w_entry.alu_ctrl  = arith_ctrl(w_f3, i_instr[30], 1'b1);
                w_entry.a         = i_rs1;
                w_entry.b         = i_rs2;
                w_entry.reg_write = 1'b1;
            end
            OPC_OPIMM: begin
                w_entry.alu_ctrl  = arith_ctrl(w_f3, i_instr[30], 1'b0);
                w_entry.a         = i_rs1;
                w_entry.b         = w_imm_i;
                w_entry.imm       = w_imm_i;
                w_entry.reg_write = 1'b1;
                if ((w_f3 == 3'b001 || w_f3 == 3'b101) &&
                    i_instr[31:25] != 7'b0000000 && i_instr[31:25] != 7'b0100000)
                    w_entry.illegal = 1'b1;
            end
            OPC_LOAD: begin
                w_entry.kind      = KIND_LOAD;
                w_entry.a         = i_rs1;
                w_entry.b         = w_imm_i;
                w_entry.imm       = w_imm_i;
                w_entry.reg_write = 1'b1;
            end
            OPC_STORE: begin
                w_entry.kind = KIND_STORE;
                w_entry.a    = i_rs1;
                w_entry.b    = w_imm_s;
                w_entry.imm  = w_imm_s;
            end
            OPC_BRANCH: begin
                w_entry.kind = KIND_BRANCH;
                w_entry.a    = i_rs1;
                w_entry.b    = i_rs2;
                w_entry.imm  = w_imm_b;
                case (w_f3[2:1])
                    2'b00:   w_entry.alu_ctrl = ALU_SUB;
                    2'b10:   w_entry.alu_ctrl = ALU_SLT;
                    2'b11:   w_entry.alu_ctrl = ALU_SLTU;
                    default: w_entry.illegal  = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                w_entry.kind      = KIND_JUMP;
                w_entry.a         = i_pc;
                w_entry.b         = 32'd4;
                w_entry.imm       = (w_opcode == OPC_JAL) ? w_imm_j : w_imm_i;
                w_entry.reg_write = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_entry.a         = (w_opcode == OPC_AUIPC) ? i_pc : 32'd0;
                w_entry.b         = w_imm_u;
                w_entry.imm       = w_imm_u;
                w_entry.reg_write = 1'b1;
            end
            default: w_entry.illegal = 1'b1;
        endcase
        // Writes to x0 and anything undecodable never reach the register file.
        if (w_entry.illegal || w_entry.rd == 5'd0)
            w_entry.reg_write = 1'b0;
    end

    assign o_entry = w_entry;

endmodule

// File: rtl/alu_issue.sv
// ID->EX issue stage: decodes each accepted instruction and holds it in a
// 2-entry FIFO skid buffer with a registered in_ready.
`timescale 1ns/1ps
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_alu_ctrl,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic [2:0]  out_funct3,
    output logic [2:0]  out_kind,
    output logic        out_illegal
);

    entry_t     w_dec;
    entry_t     w_head;
    entry_t     r_mem [ISSUE_DEPTH];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       r_in_ready;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_count_next;

    alu_decode u_decode (
        .i_instr (in_instr),
        .i_pc    (in_pc),
        .i_rs1   (in_rs1),
        .i_rs2   (in_rs2),
        .o_entry (w_dec)
    );

    assign w_push       = in_valid && r_in_ready;
    assign w_pop        = out_valid && out_ready;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

    // Flush wins over any push or pop in the same cycle; stored data is left stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_in_ready <= 1'b1;
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
        end else if (flush) begin
            r_count    <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_dec;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < 2'd2);
        end
    end

    assign w_head        = r_mem[r_rptr];
    assign in_ready      = r_in_ready;
    assign out_valid     = (r_count != 2'd0);
    assign out_a         = w_head.a;
    assign out_b         = w_head.b;
    assign out_alu_ctrl  = w_head.alu_ctrl;
    assign out_imm       = w_head.imm;
    assign out_pc        = w_head.pc;
    assign out_rd        = w_head.rd;
    assign out_reg_write = w_head.reg_write;
    assign out_funct3    = w_head.funct3;
    assign out_kind      = w_head.kind;
    assign out_illegal   = w_head.illegal;

endmodule
